// File: rtl/rail_seq_pkg.sv
// Shared types and width helpers for the PMIC rail sequencer.
package rail_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DELAY    = 3'd1,
        S_WAIT_PG  = 3'd2,
        S_ON       = 3'd3,
        S_SHUTDOWN = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    // Rail index width; matches the width of the fault_rail_o port (up to 8 rails).
    localparam int IDX_W = 3;

    // Bits needed to hold a counter that runs 0..max_val (never narrower than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rail_sequencer_tick_gen.sv
// Free-running prescaler: one-clk tick every DIV+1 clocks, async active-low reset.
module tick_gen
    import rail_seq_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int               CNT_W = cnt_w(DIV);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == TERM);
    assign tick_o = w_tick;

    // Count 0..DIV and wrap on the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rail_sequencer.sv
// PMIC rail sequencer: ascending power-up, descending power-down, pgood fault latch.
module rail_sequencer
    import rail_seq_pkg::*;
#(
    parameter int NUM_RAILS = 4,
    parameter int DIV       = 2,
    parameter int DELAY_W   = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [DELAY_W-1:0]   delay_i,
    input  logic [NUM_RAILS-1:0] pgood_i,
    output logic [NUM_RAILS-1:0] rail_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fault_o,
    output logic [2:0]           fault_rail_o,
    output state_t               dbg_state_o
);

    localparam int               TCNT_W   = cnt_w(TIMEOUT);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RAILS - 1);

    state_t               r_state,      w_state_nxt;
    logic [NUM_RAILS-1:0] r_rail_en,    w_rail_en_nxt;
    logic [DELAY_W-1:0]   r_dly,        w_dly_nxt;
    logic [DELAY_W-1:0]   r_dcnt,       w_dcnt_nxt;
    logic [TCNT_W-1:0]    r_tcnt,       w_tcnt_nxt;
    logic [IDX_W-1:0]     r_idx,        w_idx_nxt;
    logic [IDX_W-1:0]     r_fault_rail, w_fault_rail_nxt;

    logic                 w_tick;
    logic [NUM_RAILS-1:0] w_mask;
    logic                 w_pg_idx;
    logic                 w_all_good;
    logic                 w_dly_hit;
    logic [IDX_W-1:0]     w_low_idx;

    tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_o (w_tick)
    );

    assign w_mask     = {{(NUM_RAILS-1){1'b0}}, 1'b1} << r_idx;
    assign w_pg_idx   = |(pgood_i & w_mask);
    assign w_all_good = &pgood_i;
    assign w_dly_hit  = (r_dcnt == r_dly);

    // Lowest-numbered rail whose power-good is low (reported on a fault from ON).
    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (!pgood_i[i]) w_low_idx = IDX_W'(i);
        end
    end

    // State register together with the datapath registers it steers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rail_en    <= '0;
            r_dly        <= '0;
            r_dcnt       <= '0;
            r_tcnt       <= '0;
            r_idx        <= '0;
            r_fault_rail <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rail_en    <= w_rail_en_nxt;
            r_dly        <= w_dly_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_tcnt       <= w_tcnt_nxt;
            r_idx        <= w_idx_nxt;
            r_fault_rail <= w_fault_rail_nxt;
        end
    end

    // Next-state and next-datapath decision.
    always_comb begin
        w_state_nxt      = r_state;
        w_rail_en_nxt    = r_rail_en;
        w_dly_nxt        = r_dly;
        w_dcnt_nxt       = r_dcnt;
        w_tcnt_nxt       = r_tcnt;
        w_idx_nxt        = r_idx;
        w_fault_rail_nxt = r_fault_rail;
        case (r_state)
            S_IDLE: begin
                w_rail_en_nxt = '0;
                if (en_i) begin
                    w_dly_nxt   = delay_i;
                    w_idx_nxt   = '0;
                    w_dcnt_nxt  = '0;
                    w_state_nxt = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!en_i) begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = S_SHUTDOWN;
                end else if (w_dly_hit) begin
                    w_rail_en_nxt = r_rail_en | w_mask;
                    w_tcnt_nxt    = '0;
                    w_state_nxt   = S_WAIT_PG;
                end else if (w_tick) begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            S_WAIT_PG: begin
                // pgood wins over a timeout that expires in the same cycle.
                if (!en_i) begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = S_SHUTDOWN;
                end else if (w_pg_idx) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_ON;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_dcnt_nxt  = '0;
                        w_state_nxt = S_DELAY;
                    end
                end else if (r_tcnt == TCNT_MAX) begin
                    w_fault_rail_nxt = r_idx;
                    w_rail_en_nxt    = '0;
                    w_state_nxt      = S_FAULT;
                end else if (w_tick) begin
                    // Never passes TCNT_MAX: reaching it forces FAULT first.
                    w_tcnt_nxt = r_tcnt + 1'b1;
                end
            end
            S_ON: begin
                if (!w_all_good) begin
                    w_fault_rail_nxt = w_low_idx;
                    w_rail_en_nxt    = '0;
                    w_state_nxt      = S_FAULT;
                end else if (!en_i) begin
                    w_idx_nxt   = LAST_IDX;
                    w_dcnt_nxt  = '0;
                    w_state_nxt = S_SHUTDOWN;
                end
            end
            S_SHUTDOWN: begin
                // en_i and pgood are deliberately ignored until IDLE.
                if (w_dly_hit) begin
                    w_rail_en_nxt = r_rail_en & ~w_mask;
                    w_dcnt_nxt    = '0;
                    if (r_idx == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx - 1'b1;
                    end
                end else if (w_tick) begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            S_FAULT: begin
                w_rail_en_nxt = '0;
                if (!en_i) begin
                    w_fault_rail_nxt = '0;
                    w_state_nxt      = S_IDLE;
                end
            end
            default: begin
                w_rail_en_nxt = '0;
                w_state_nxt   = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        busy_o       = 1'b0;
        done_o       = 1'b0;
        fault_o      = 1'b0;
        rail_en_o    = r_rail_en;
        fault_rail_o = r_fault_rail;
        dbg_state_o  = r_state;
        case (r_state)
            S_DELAY, S_WAIT_PG, S_SHUTDOWN: busy_o  = 1'b1;
            S_ON:                           done_o  = 1'b1;
            S_FAULT:                        fault_o = 1'b1;
            default:                        busy_o  = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rail_sequencer.sv
// Bench for rail_sequencer: directed scenarios, output-change scoreboard, timing windows.
module tb_rail_sequencer;
    import rail_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_i;
    logic [7:0] delay_i;
    logic [3:0] pgood_i;
    logic [3:0] rail_en_o;
    logic       busy_o;
    logic       done_o;
    logic       fault_o;
    logic [2:0] fault_rail_o;
    state_t     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Snapshot layout: {fault, fault_rail[2:0], done, busy, rail_en[3:0]}
    logic [9:0] exp_q[$];
    logic [9:0] prev_snap = '0;
    logic [9:0] cur_snap;
    logic [9:0] mon_exp;
    int         cyc;

    rail_sequencer #(.NUM_RAILS(4), .DIV(2), .DELAY_W(8), .TIMEOUT(200)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .delay_i      (delay_i),
        .pgood_i      (pgood_i),
        .rail_en_o    (rail_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .fault_o      (fault_o),
        .fault_rail_o (fault_rail_o),
        .dbg_state_o  (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    assign cur_snap = {fault_o, fault_rail_o, done_o, busy_o, rail_en_o};

    // Monitor: every change of the observed outputs pops one expected snapshot.
    always @(negedge clk) begin
        if (cur_snap !== prev_snap) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h, required no change from %h", cur_snap, prev_snap);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cur_snap !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_snapshot: got %h, required %h at %0t", cur_snap, mon_exp, $time);
                end
            end
            prev_snap = cur_snap;
        end
    end

    function automatic logic [9:0] snap(input logic f, input logic [2:0] fr, input logic d,
                                        input logic b, input logic [3:0] r);
        return {f, fr, d, b, r};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d", nm, act, lo, hi);
        end
    endtask

    // kind 0: rail_en_o == val, 1: done_o, 2: fault_o
    function automatic bit cond_met(input int kind, input logic [3:0] val);
        case (kind)
            0:       return rail_en_o === val;
            1:       return done_o === 1'b1;
            2:       return fault_o === 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_until(input string nm, input int kind, input logic [3:0] val,
                              input int budget, output int n);
        n = 0;
        while (!cond_met(kind, val) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!cond_met(kind, val)) begin
            n_fail++;
            $display("FAIL %s: condition not reached, got rails=%b done=%b fault=%b, required within %0d clks",
                     nm, rail_en_o, done_o, fault_o, budget);
        end
    endtask

    task automatic push_powerup(input int n_up, input bit to_on);
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b1, 4'b0000));
        for (int i = 1; i <= n_up; i++) begin
            exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b1, 4'((1 << i) - 1)));
        end
        if (to_on) exp_q.push_back(snap(1'b0, 3'd0, 1'b1, 1'b0, 4'b1111));
    endtask

    task automatic push_shutdown();
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b1, 4'b1111));
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b1, 4'b0111));
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b1, 4'b0011));
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b1, 4'b0001));
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b0, 4'b0000));
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst_n   = 1'b0;
        en_i    = 1'b0;
        delay_i = 8'd0;
        pgood_i = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_rails", rail_en_o, 4'b0000);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_fault", fault_o, 1'b0);
        check("rst_fault_rail", fault_rail_o, 3'd0);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        // Power-up, delay 2, pgood follows each enable
        push_powerup(4, 1'b1);
        delay_i = 8'd2;
        en_i    = 1'b1;
        for (int r = 0; r < 4; r++) begin
            wait_until($sformatf("up_rail%0d", r), 0, 4'((1 << (r + 1)) - 1), 20, cyc);
            check_rng($sformatf("up_gap_rail%0d", r), cyc, 5, 9);
            pgood_i = rail_en_o;
        end
        wait_until("up_done", 1, 4'b0, 4, cyc);
        check_rng("up_done_lat", cyc, 1, 1);
        check("up_busy", busy_o, 1'b0);
        check("up_state", dbg_state, S_ON);

        // pgood[1] glitch in ON
        exp_q.push_back(snap(1'b1, 3'd1, 1'b0, 1'b0, 4'b0000));
        pgood_i = 4'b1101;
        @(negedge clk);
        pgood_i = 4'b1111;
        check("glitch_fault", fault_o, 1'b1);
        check("glitch_fault_rail", fault_rail_o, 3'd1);
        check("glitch_rails", rail_en_o, 4'b0000);
        repeat (4) @(negedge clk);
        check("fault_hold", fault_o, 1'b1);
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b0, 4'b0000));
        en_i = 1'b0;
        @(negedge clk);
        check("fault_clear", fault_o, 1'b0);
        check("fault_rail_clear", fault_rail_o, 3'd0);
        check("fault_exit_state", dbg_state, S_IDLE);

        // delay 0, pgood tied high
        push_powerup(4, 1'b1);
        delay_i = 8'd0;
        en_i    = 1'b1;
        wait_until("fast_done", 1, 4'b0, 12, cyc);
        check_rng("fast_up_lat", cyc, 2, 9);
        push_shutdown();
        en_i = 1'b0;
        wait_until("fast_down", 0, 4'b0000, 10, cyc);
        check_rng("fast_down_lat", cyc, 5, 5);
        check("fast_down_state", dbg_state, S_IDLE);

        // delay 3 shutdown, en re-asserted mid-shutdown, new delay ignored
        push_powerup(4, 1'b1);
        delay_i = 8'd3;
        en_i    = 1'b1;
        wait_until("d3_done", 1, 4'b0, 200, cyc);
        push_shutdown();
        push_powerup(4, 1'b1);
        delay_i = 8'd0;
        en_i    = 1'b0;
        wait_until("dn_rail3", 0, 4'b0111, 20, cyc);
        check_rng("dn_gap_rail3", cyc, 8, 11);
        en_i = 1'b1;
        wait_until("dn_rail2", 0, 4'b0011, 20, cyc);
        check_rng("dn_gap_rail2", cyc, 8, 11);
        wait_until("dn_rail1", 0, 4'b0001, 20, cyc);
        check_rng("dn_gap_rail1", cyc, 8, 11);
        wait_until("dn_rail0", 0, 4'b0000, 20, cyc);
        check_rng("dn_gap_rail0", cyc, 8, 11);
        check("dn_idle_state", dbg_state, S_IDLE);
        wait_until("restart_done", 1, 4'b0, 20, cyc);
        check_rng("restart_lat", cyc, 9, 9);

        // Timeout on rail 2
        push_shutdown();
        en_i = 1'b0;
        wait_until("to_pre_down", 0, 4'b0000, 10, cyc);
        pgood_i = 4'b1011;
        delay_i = 8'd1;
        push_powerup(3, 1'b0);
        exp_q.push_back(snap(1'b1, 3'd2, 1'b0, 1'b0, 4'b0000));
        en_i = 1'b1;
        wait_until("to_rail2", 0, 4'b0111, 40, cyc);
        wait_until("to_fault", 2, 4'b0, 700, cyc);
        check_rng("timeout_lat", cyc, 595, 605);
        check("to_fault_rail", fault_rail_o, 3'd2);
        check("to_rails", rail_en_o, 4'b0000);
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b0, 4'b0000));
        en_i = 1'b0;
        @(negedge clk);
        check("to_clear", fault_o, 1'b0);

        // Async reset in WAIT_PG at rail 2
        pgood_i = 4'b0011;
        delay_i = 8'd1;
        push_powerup(3, 1'b0);
        en_i = 1'b1;
        wait_until("rs_rail2", 0, 4'b0111, 40, cyc);
        repeat (3) @(negedge clk);
        check("rs_wait_state", dbg_state, S_WAIT_PG);
        exp_q.push_back(snap(1'b0, 3'd0, 1'b0, 1'b0, 4'b0000));
        push_powerup(4, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rs_async_rails", rail_en_o, 4'b0000);
        check("rs_async_state", dbg_state, S_IDLE);
        @(negedge clk);
        rst_n   = 1'b1;
        pgood_i = 4'b1111;
        wait_until("rs_restart_rail0", 0, 4'b0001, 20, cyc);
        wait_until("rs_done", 1, 4'b0, 40, cyc);

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rail_sequencer.md
Name: rail_sequencer

Overview:
- Power-up/power-down sequencer for the PMIC rail enables.
- Brings up NUM_RAILS rails in ascending order and shuts them down in descending order.
- The gap between steps is a programmable number of slow ticks, produced by an internal prescaler (the timebase block).
- Monitors per-rail power-good and latches a fault on timeout or loss of power-good.

Parameters:
- NUM_RAILS, 4, number of sequenced rails (2..8).
- DIV, 2, prescaler terminal count; one tick per DIV+1 clk cycles.
- DELAY_W, 8, width of step-delay input.
- TIMEOUT, 200, ticks allowed for pgood after a rail is enabled.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en_i  in  1  level request: 1 = rails up, 0 = rails down.
- delay_i  in  DELAY_W  inter-step delay in ticks; latched when a sequence starts.
- pgood_i  in  NUM_RAILS  per-rail power-good, already synchronised.
- rail_en_o  out  NUM_RAILS  rail enables, registered.
- busy_o  out  1  sequencing in progress (DELAY/WAIT_PG/SHUTDOWN).
- done_o  out  1  all rails up and good (state ON).
- fault_o  out  1  sticky fault flag.
- fault_rail_o  out  3  index of faulting rail.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, prescaler/idx/counters 0. Reset mid-sequence drops every rail at once.
- Prescaler: free-running count 0..DIV. tick=1 for exactly one clk when count==DIV, then wraps to 0. Runs in all states.
- States: IDLE, DELAY, WAIT_PG, ON, SHUTDOWN, FAULT. All outputs are registered and change on the clk edge after the transition decision.
- IDLE:
  - rail_en_o=0.
  - If en_i=1: latch dly=delay_i, idx=0, dcnt=0, go to DELAY.
- DELAY:
  - If dcnt==dly: set rail_en_o[idx], tcnt=0, go to WAIT_PG.
  - Else dcnt++ on each tick.
  - dly=0 means DELAY lasts exactly 1 clk.
- WAIT_PG:
  - If pgood_i[idx]=1:
    - If idx==NUM_RAILS-1, go to ON.
    - Else idx++, dcnt=0, go to DELAY.
  - Otherwise tcnt++ on each tick. When tcnt reaches TIMEOUT, go to FAULT with fault_rail_o=idx.
  - pgood has priority over timeout in the same cycle.
- ON:
  - done_o=1.
  - Any pgood_i bit 0 goes to FAULT, with fault_rail_o = lowest index that is low.
  - Else if en_i=0: idx=NUM_RAILS-1, dcnt=0, go to SHUTDOWN.
  - Fault has priority over en_i=0.
- en_i=0 during DELAY/WAIT_PG: go to SHUTDOWN starting from the current idx. dcnt=0.
- SHUTDOWN:
  - Wait dly ticks (same counting rule as DELAY), then clear rail_en_o[idx].
  - If idx==0, go to IDLE; else idx--, dcnt=0.
  - en_i re-asserted mid-shutdown is ignored until IDLE is reached. IDLE then restarts on the next clk if en_i is still 1.
  - pgood is not checked during SHUTDOWN.
- FAULT:
  - rail_en_o cleared on entry, all at once.
  - fault_o=1; fault_rail_o held.
  - Exit to IDLE only when en_i=0 is seen; fault_o and fault_rail_o clear on that exit.
- busy_o=1 in DELAY, WAIT_PG and SHUTDOWN; 0 in IDLE, ON and FAULT.
- Counter widths:
  - dcnt is DELAY_W bits.
  - tcnt is clog2(TIMEOUT+1) bits and saturates.
  - Prescaler is clog2(DIV+1) bits.
- delay_i changes mid-sequence have no effect; the value latched in IDLE is used for both power-up and the following shutdown.

Decomposition:
- Package rail_seq_pkg:
  - state enum (IDLE, DELAY, WAIT_PG, ON, SHUTDOWN, FAULT);
  - width helpers (clog2-based) for the counters.
- Sub-module tick_gen: parameter DIV, ports clk, rst_n, tick_o. It is the async-reset version of the existing slow-clock divider and is instantiated once.

Test Plan:
- Power-up, DIV=2, delay_i=2, pgood follows each enable after 1 clk:
  - rails enable 0→3 in order, spaced 2 ticks (6 clks) ± 1 tick phase;
  - done_o=1 after rail 3's pgood; busy_o=0.
- delay_i=0, pgood tied high: all four enables set on consecutive 2-clk steps; done_o after ≤ 9 clks.
- Timeout, TIMEOUT=200, pgood_i[2] stuck 0:
  - after 200 ticks (600 clks) in WAIT_PG: fault_o=1, fault_rail_o=2, rail_en_o=0;
  - en_i=0 then clears the fault.
- From ON, drop pgood_i[1] for 1 clk: FAULT, fault_rail_o=1, all enables 0 next edge.
- Shutdown, delay_i=3, from ON with en_i=0:
  - rails clear in order 3,2,1,0, each 3 ticks apart; state IDLE after rail 0;
  - en_i pulsed high mid-shutdown does not stop it, and power-up restarts once IDLE is reached.
- rst_n asserted while in WAIT_PG at idx=2: rail_en_o=0 asynchronously; after release, sequence restarts from rail 0.
